// File: rtl/mem_addr_arbiter.sv
// Registered arbiter between the instruction-fetch (PC) and data (MAR) ports for the single memory address bus.
// Optional fetch anti-starvation counter is enabled by defining STARVE_GUARD_EN.
module mem_addr_arbiter #(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
  parameter int unsigned       STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_we,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] address_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic              fetch_done,
  output logic              data_done,
  output logic              busy
);

  // Handshake: a requester holds its req level until its done pulse; memory
  // sees mem_req=1 with a stable address_bus/mem_we until it returns mem_ack=1.
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d, fdone_d, ddone_d;
  logic              fetch_elig, data_elig, grant_data, grant_fetch;

`ifdef STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [CNT_W-1:0] starve_q, starve_d;
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
`endif

  assign mem_req = (state_q == ACCESS);
  assign busy    = (state_q == ACCESS);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    addr_d     = address_bus;
    we_d       = mem_we;
    fdone_d    = 1'b0;
    ddone_d    = 1'b0;
    // A request whose done pulse is showing is the one just served, not a new one.
    fetch_elig = fetch_req && !fetch_done;
    data_elig  = data_req && !data_done;
    grant_data = data_elig;
`ifdef STARVE_GUARD_EN
    starve_d   = starve_q;
    if (fetch_elig && data_elig && (starve_q == CNT_W'(STARVE_LIMIT)))
      grant_data = 1'b0;
`endif
    grant_fetch = fetch_elig && !grant_data;

    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (grant_data) begin
          state_d = ACCESS;
          src_d   = SRC_DATA;
          addr_d  = data_addr;
          we_d    = data_we;
`ifdef STARVE_GUARD_EN
          // Saturates so a data grant while fetch is merely suppressed cannot wrap.
          if (!fetch_req)
            starve_d = '0;
          else if (starve_q != CNT_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
`endif
        end else if (grant_fetch) begin
          state_d = ACCESS;
          src_d   = SRC_FETCH;
          addr_d  = fetch_addr;
`ifdef STARVE_GUARD_EN
          starve_d = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = IDLE;
          we_d    = 1'b0;
          fdone_d = (src_q == SRC_FETCH);
          ddone_d = (src_q == SRC_DATA);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_FETCH;
      address_bus <= RESET_ADDR;
      mem_we      <= 1'b0;
      fetch_done  <= 1'b0;
      data_done   <= 1'b0;
`ifdef STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      address_bus <= addr_d;
      mem_we      <= we_d;
      fetch_done  <= fdone_d;
      data_done   <= ddone_d;
`ifdef STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

endmodule
